alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 40 ++++
 rtl/alu_arbiter_alu.sv | 41 ++++
 rtl/alu_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU and the main control
// decoder, plus the response slot record held by the arbiter.
package alu_pkg;

  // Only a 32-bit datapath is supported.
  localparam int ALU_W = 32;

  // ALU control codes.
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  // Single response slot: one buffered result and the requester that owns it.
  typedef struct packed {
    logic             valid;
    logic             owner;
    logic [ALU_W-1:0] result;
    logic             zero;
  } slot_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU bus: request handshake per requester plus a shared
// response data path qualified by per-requester response valids.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [3:0]        req0_op;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic              rsp0_ready;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  // Requester side.
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req1_a, req0_b, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req1_a, req0_b, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: AND, OR, ADD, SUB, unsigned SLT, NOR. Unknown control
// codes yield zero. The arbiter registers the result, so no state here.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [3:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic lt_s;

  // Unsigned compare feeding SLT.
  always_comb begin
    lt_s = (data1 < data2);
  end

  // Operation select; arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (alu_control)
      ALU_AND: result = data1 & data2;
      ALU_OR:  result = data1 | data2;
      ALU_ADD: result = data1 + data2;
      ALU_SUB: result = data1 - data2;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_NOR: result = ~(data1 | data2);
      default: result = {DATA_W{1'b0}};
    endcase
  end

  // Zero flag of the selected result.
  always_comb begin
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. Accepted
// operations land in a single response slot one cycle later; the slot can be
// drained and refilled on the same edge for one operation per cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  slot_t             slot_r;
  logic              last_grant_r;

  logic              grant_valid_s;
  logic              grant_s;
  logic              slot_free_s;
  logic              accept_s;
  logic [3:0]        alu_op_s;
  logic [DATA_W-1:0] alu_a_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_zero_s;

  // Pick a requester; on a tie the one not granted at the last accept wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = ~last_grant_r;
    end else if (bus.req0_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b0;
    end else if (bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  // Slot can take a new result when empty or being consumed by its owner.
  always_comb begin
    slot_free_s = 1'b0;
    if (!slot_r.valid) begin
      slot_free_s = 1'b1;
    end else if (slot_r.owner) begin
      slot_free_s = bus.rsp1_ready;
    end else begin
      slot_free_s = bus.rsp0_ready;
    end
  end

  // Handshake: only one ready can rise because only one grant exists.
  always_comb begin
    accept_s       = !rst && grant_valid_s && slot_free_s;
    bus.req0_ready = accept_s && (grant_s == 1'b0);
    bus.req1_ready = accept_s && (grant_s == 1'b1);
  end

  // Route the granted requester's operation into the shared ALU.
  always_comb begin
    alu_op_s = bus.req0_op;
    alu_a_s  = bus.req0_a;
    alu_b_s  = bus.req0_b;
    if (grant_s) begin
      alu_op_s = bus.req1_op;
      alu_a_s  = bus.req1_a;
      alu_b_s  = bus.req1_b;
    end else begin
      alu_op_s = bus.req0_op;
      alu_a_s  = bus.req0_a;
      alu_b_s  = bus.req0_b;
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .data1       (alu_a_s),
    .data2       (alu_b_s),
    .alu_control (alu_op_s),
    .result      (alu_result_s),
    .zero        (alu_zero_s)
  );

  // Slot and round-robin state: load on accept, clear on drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r.valid  <= 1'b0;
      slot_r.owner  <= 1'b0;
      slot_r.result <= {DATA_W{1'b0}};
      slot_r.zero   <= 1'b0;
      last_grant_r  <= 1'b1;
    end else if (accept_s) begin
      slot_r.valid  <= 1'b1;
      slot_r.owner  <= grant_s;
      slot_r.result <= alu_result_s;
      slot_r.zero   <= alu_zero_s;
      last_grant_r  <= grant_s;
    end else if (slot_r.valid && slot_free_s) begin
      slot_r.valid  <= 1'b0;
    end
  end

  // Response outputs come straight from the slot; masked while in reset.
  always_comb begin
    bus.rsp0_valid = !rst && slot_r.valid && (slot_r.owner == 1'b0);
    bus.rsp1_valid = !rst && slot_r.valid && (slot_r.owner == 1'b1);
    bus.rsp_result = slot_r.result;
    bus.rsp_zero   = slot_r.zero;
  end

endmodule
